adder_seq_ctrl: RTL and testbench

Sequencing controller for the 4-bit parallel-adder lab datapath. It captures two 4-bit operands from switches on successive button presses and forms their 5-bit sum. The sum is converted to two BCD digits with a sequential shift-add-3 engine. Both digits drive a time-multiplexed two-digit 7-segment display. It sits between the board switches/buttons and the seven-segment decoder, replacing the purely combinational binary-to-BCD path.

---
 rtl/adder_ctrl_pkg.sv | 33 +++
 rtl/btn_edge.sv | 27 ++
 rtl/adder_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared types, constants and the double-dabble step for the adder sequencing controller.
package adder_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        ADD,
        CONV,
        SHOW
    } state_t;

    localparam int unsigned BCD_ITER = 5;
    localparam int unsigned ITER_W   = 3;
    localparam int unsigned OPND_W   = 4;
    localparam int unsigned SUM_W    = 5;
    localparam int unsigned BCD_W    = 4;
    localparam int unsigned SCR_W    = 8;

    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

    // One shift-add-3 iteration: correct each nibble >= 5, then shift in the next sum bit.
    function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] scr,
                                                     input logic             bit_in);
        logic [BCD_W-1:0] hi;
        logic [BCD_W-1:0] lo;
        hi = (scr[7:4] >= 4'd5) ? scr[7:4] + 4'd3 : scr[7:4];
        lo = (scr[3:0] >= 4'd5) ? scr[3:0] + 4'd3 : scr[3:0];
        return {hi[2:0], lo, bit_in};
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus rising-edge detector; one pulse per button press.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse_c
);

    logic sync_q;
    logic sync_qq;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 1'b0;
            sync_qq <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= btn;
            sync_qq <= sync_q;
            prev_q  <= sync_qq;
        end
    end

    assign pulse_c = sync_qq & ~prev_q;

endmodule

// File: rtl/adder_seq_ctrl.sv
// Operand capture, 5-bit add, sequential binary-to-BCD conversion and two-digit display scan.
module adder_seq_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPND_W-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clr,
    output logic [OPND_W-1:0] op_a,
    output logic [OPND_W-1:0] op_b,
    output logic [SUM_W-1:0]  sum,
    output logic [BCD_W-1:0]  ten_bcd,
    output logic [BCD_W-1:0]  one_bcd,
    output logic             busy,
    output logic             done,
    output logic [1:0]       an,
    output logic [BCD_W-1:0]  digit_bcd
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BCD_ITER - 1);

    logic load_p;
    logic clr_p;

    state_t            state;
    logic [SCR_W-1:0]  scratch;
    logic [ITER_W-1:0] iter;
    logic [ITER_W-1:0] bit_idx;
    logic [SCR_W-1:0]  step;

    logic [SCAN_W-1:0] scan_cnt;
    logic              slot;

    btn_edge u_load_edge (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn_load),
        .pulse_c (load_p)
    );

    btn_edge u_clr_edge (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn_clr),
        .pulse_c (clr_p)
    );

    // Next scratch value; the sum is consumed MSB first.
    always_comb begin
        bit_idx = ITER_LAST - iter;
        step    = dabble_step(scratch, sum[bit_idx]);
    end

    // Sequencing FSM with registered datapath and status outputs; clear beats everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_A;
            op_a    <= '0;
            op_b    <= '0;
            sum     <= '0;
            ten_bcd <= '0;
            one_bcd <= '0;
            scratch <= '0;
            iter    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr_p) begin
                state   <= WAIT_A;
                op_a    <= '0;
                op_b    <= '0;
                sum     <= '0;
                ten_bcd <= '0;
                one_bcd <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    WAIT_A: begin
                        if (load_p) begin
                            op_a  <= sw;
                            state <= WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (load_p) begin
                            op_b  <= sw;
                            busy  <= 1'b1;
                            state <= ADD;
                        end
                    end
                    ADD: begin
                        sum     <= {1'b0, op_a} + {1'b0, op_b};
                        scratch <= '0;
                        iter    <= '0;
                        state   <= CONV;
                    end
                    CONV: begin
                        scratch <= step;
                        iter    <= iter + 1'b1;
                        if (iter == ITER_LAST) begin
                            ten_bcd <= step[7:4];
                            one_bcd <= step[3:0];
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (load_p) begin
                            op_a  <= sw;
                            state <= WAIT_B;
                        end
                    end
                    default: begin
                        state <= WAIT_A;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Free-running slot timer, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            slot     <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            slot     <= ~slot;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Decoded straight from registers so a new digit shows in the current slot.
    always_comb begin
        an        = AN_ONES;
        digit_bcd = one_bcd;
        if (slot) begin
            digit_bcd = ten_bcd;
            an        = (ten_bcd == '0) ? AN_OFF : AN_TENS;
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl with a short scan period.
module tb_adder_seq_ctrl;
    import adder_ctrl_pkg::*;

    localparam int unsigned SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       btn_load;
    logic       btn_clr;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [4:0] sum;
    logic [3:0] ten_bcd;
    logic [3:0] one_bcd;
    logic       busy;
    logic       done;
    logic [1:0] an;
    logic [3:0] digit_bcd;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] s;
        logic [3:0] ten;
        logic [3:0] one;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_vec  = 0;
    int         n_err  = 0;
    int         n_done = 0;
    int         cyc    = 0;
    logic [3:0] last_a = '0;
    logic [3:0] cur_ten = '0;
    logic [3:0] cur_one = '0;
    int         mcnt   = 0;
    bit         mslot  = 1'b0;

    adder_seq_ctrl #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_load  (btn_load),
        .btn_clr   (btn_clr),
        .op_a      (op_a),
        .op_b      (op_b),
        .sum       (sum),
        .ten_bcd   (ten_bcd),
        .one_bcd   (one_bcd),
        .busy      (busy),
        .done      (done),
        .an        (an),
        .digit_bcd (digit_bcd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference slot timer.
    always @(posedge clk) begin
        if (rst) begin
            mcnt  <= 0;
            mslot <= 1'b0;
        end else if (mcnt == int'(SD) - 1) begin
            mcnt  <= 0;
            mslot <= ~mslot;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: each done pulse must match the oldest pending operation.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_op_a", op_a, e.a);
                check("done_op_b", op_b, e.b);
                check("done_sum", sum, e.s);
                check("done_ten", ten_bcd, e.ten);
                check("done_one", one_bcd, e.one);
                check("done_lat", cyc, e.cyc);
                check("done_busy", busy, 0);
                cur_ten = e.ten;
                cur_one = e.one;
            end
        end
    end

    // Raise load at a negedge; the register captures on the 3rd rising edge.
    task automatic press(input logic [3:0] v, input bit second, input bit push);
        exp_t e;
        @(negedge clk);
        sw       = v;
        btn_load = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (second) begin
            check("op_b", op_b, v);
            check("busy_add", busy, 1);
            if (push) begin
                e.a   = last_a;
                e.b   = v;
                e.s   = 5'({1'b0, last_a} + {1'b0, v});
                e.ten = 4'(int'(e.s) / 10);
                e.one = 4'(int'(e.s) % 10);
                e.cyc = cyc + 6;
                sb.push_back(e);
            end
        end else begin
            check("op_a", op_a, v);
            check("state_b", int'(dut.state), int'(WAIT_B));
            last_a = v;
        end
        btn_load = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 1, 0);
            sb.delete();
        end
    endtask

    task automatic scan_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("scan_an", an, mslot ? ((cur_ten == 0) ? 3 : 1) : 2);
            check("scan_digit", digit_bcd, mslot ? cur_ten : cur_one);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_state"}, int'(dut.state), int'(WAIT_A));
        check({tag, "_op_a"}, op_a, 0);
        check({tag, "_op_b"}, op_b, 0);
        check({tag, "_sum"}, sum, 0);
        check({tag, "_ten"}, ten_bcd, 0);
        check({tag, "_one"}, one_bcd, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        cur_ten = '0;
        cur_one = '0;
    endtask

    initial begin
        rst      = 1'b1;
        sw       = '0;
        btn_load = 1'b0;
        btn_clr  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        check("reset_scan_cnt", int'(dut.scan_cnt), 0);
        check("reset_an", an, 2);
        check("reset_digit", digit_bcd, 0);
        rst = 1'b0;

        press(4'd9, 1'b0, 1'b0);
        press(4'd7, 1'b1, 1'b1);
        wait_idle();
        scan_check(10);

        press(4'd15, 1'b0, 1'b0);
        press(4'd15, 1'b1, 1'b1);
        wait_idle();
        scan_check(12);

        press(4'd0, 1'b0, 1'b0);
        press(4'd0, 1'b1, 1'b1);
        wait_idle();
        scan_check(10);

        // Clear from SHOW.
        @(negedge clk);
        btn_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("clr_show");
        btn_clr = 1'b0;
        repeat (3) @(negedge clk);

        // Held load button: exactly one capture.
        @(negedge clk);
        sw       = 4'd5;
        btn_load = 1'b1;
        repeat (20) @(negedge clk);
        check("held_state", int'(dut.state), int'(WAIT_B));
        check("held_op_a", op_a, 5);
        btn_load = 1'b0;
        last_a   = 4'd5;
        repeat (3) @(negedge clk);
        press(4'd3, 1'b1, 1'b1);
        wait_idle();

        // Clear landing on the 3rd CONV edge (E+4).
        press(4'd8, 1'b0, 1'b0);
        @(negedge clk);
        sw       = 4'd8;
        btn_load = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("conv_op_b", op_b, 8);
        btn_load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        btn_clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("conv_pre_clr_state", int'(dut.state), int'(CONV));
        @(posedge clk);
        @(negedge clk);
        check_cleared("clr_conv");
        btn_clr = 1'b0;
        repeat (8) @(negedge clk);

        // Simultaneous load and clear in WAIT_B.
        press(4'd4, 1'b0, 1'b0);
        @(negedge clk);
        sw       = 4'd6;
        btn_load = 1'b1;
        btn_clr  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("clr_vs_load");
        btn_load = 1'b0;
        btn_clr  = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of CONV.
        press(4'd2, 1'b0, 1'b0);
        @(negedge clk);
        sw       = 4'd3;
        btn_load = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_load = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pre_state", int'(dut.state), int'(CONV));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_cleared("rst_conv");
        check("rst_conv_scan_cnt", int'(dut.scan_cnt), 0);
        check("rst_conv_an", an, 2);
        check("rst_conv_digit", digit_bcd, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        check("done_count", n_done, 4);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
